uart_tx: RTL

//  Serial UART transmitter: the TX end paired with the ALU command interface. Accepts
//  one NB_DATA-bit word on a start request and shifts it out as 8N1-style frames
//  (start, LSB-first data, stop). Reports readiness on a level flag and end of frame on
//  a one-cycle pulse. Drives the board's serial TX pin.

---
 rtl/uart_tx_pkg.sv | 30 +++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART types and helpers: FSM state encoding, baud divider math and
// counter sizing used by the transmitter and its baud tick generator.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int NB_DATA_DEF    = 8;
  localparam int OVERSAMPLE_DEF = 16;

  // Truncated clocks-per-tick, floored at 1 so tiny clock/baud ratios still tick.
  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    int d;
    d = clk_freq / (baud_rate * oversample);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-clock pulse every DIV clocks. i_clear restarts
// the period so the next pulse lands exactly DIV clocks later.
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (i_clear || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, SB_TICK-tick stop.
// Handshake: i_tx_start is taken only in IDLE; o_tx_done is the ready level and
// o_tx_done_tick pulses once, together with o_tx_done rising, at frame end.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int SB_TICK    = 16,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 19200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_tx_done_tick,
  output logic [1:0]         o_state
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = cnt_width(max2(OVERSAMPLE, SB_TICK));
  localparam int BW  = cnt_width(NB_DATA);

  localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

  tx_state_e          state_q, state_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               done_tick_q, done_tick_d;
  logic               baud_tick;
  logic               accept;

  assign accept = (state_q == ST_IDLE) && i_tx_start;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clear (accept),
    .o_tick  (baud_tick)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b1;
      done_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      done_tick_q <= done_tick_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_tx_start) begin
          shift_d    = i_tx_data;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          if (tick_cnt_q == OS_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (tick_cnt_q == OS_LAST) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (tick_cnt_q == STOP_LAST) begin
            tick_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs follow the registered state one clock later; the first IDLE cycle
  // after a frame is marked by done_q still being low.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
    done_tick_d = (state_q == ST_IDLE) && !done_q;
    done_d      = (state_q == ST_IDLE) && !(accept && !done_tick_d);
  end

  assign o_tx           = tx_q;
  assign o_tx_done      = done_q;
  assign o_tx_done_tick = done_tick_q;
  assign o_state        = state_q;

endmodule
